// File: rtl/funct_gen_pipe_pkg.sv
// Shared opcode/FUNCT/immediate-mode constants and FSM state type for funct_gen_pipe.
package funct_gen_pipe_pkg;

    localparam logic [5:0] OP_SPECIAL   = 6'h00;
    localparam logic [5:0] OP_BSPECIAL  = 6'h01;
    localparam logic [5:0] OP_JAL       = 6'h03;
    localparam logic [5:0] OP_ADDI      = 6'h08;
    localparam logic [5:0] OP_ADDIU     = 6'h09;
    localparam logic [5:0] OP_SLTI      = 6'h0A;
    localparam logic [5:0] OP_SLTIU     = 6'h0B;
    localparam logic [5:0] OP_ANDI      = 6'h0C;
    localparam logic [5:0] OP_ORI       = 6'h0D;
    localparam logic [5:0] OP_XORI      = 6'h0E;
    localparam logic [5:0] OP_LUI       = 6'h0F;
    localparam logic [5:0] OP_PRIVILEGE = 6'h10;
    localparam logic [5:0] OP_LB        = 6'h20;
    localparam logic [5:0] OP_LH        = 6'h21;
    localparam logic [5:0] OP_LW        = 6'h23;
    localparam logic [5:0] OP_LBU       = 6'h24;
    localparam logic [5:0] OP_LHU       = 6'h25;
    localparam logic [5:0] OP_SB        = 6'h28;
    localparam logic [5:0] OP_SH        = 6'h29;
    localparam logic [5:0] OP_SW        = 6'h2B;

    localparam logic [5:0] FUNCT_NOP    = 6'h00;
    localparam logic [5:0] FUNCT_ADDU   = 6'h21;
    localparam logic [5:0] FUNCT_AND    = 6'h24;
    localparam logic [5:0] FUNCT_OR     = 6'h25;
    localparam logic [5:0] FUNCT_XOR    = 6'h26;
    localparam logic [5:0] FUNCT_SLT    = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU   = 6'h2B;

    localparam logic [1:0] IMM_MODE_SIGN = 2'b00;
    localparam logic [1:0] IMM_MODE_ZERO = 2'b01;
    localparam logic [1:0] IMM_MODE_LUI  = 2'b10;
    localparam logic [1:0] IMM_MODE_NONE = 2'b11;

    typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} state_t;

    // SPECIAL funct codes the EX stage implements
    function automatic logic special_ok(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
            6'h0C, 6'h0D, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19,
            6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
            6'h26, 6'h27, 6'h2A, 6'h2B: special_ok = 1'b1;
            default:                    special_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/funct_lane_dec.sv
// Combinational single-lane op/funct -> ALU FUNCT + immediate-mode decoder.
// FUNCT_GEN_ILLEGAL_EN adds the illegal-instruction flag output.
module funct_lane_dec
    import funct_gen_pipe_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
) (
    input  logic               en,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct_in,
    output logic [FUNCT_W-1:0] funct,
`ifdef FUNCT_GEN_ILLEGAL_EN
    output logic               illegal,
`endif
    output logic [1:0]         imm_mode
);

    logic known;

    always_comb begin
        funct    = FUNCT_W'(FUNCT_NOP);
        imm_mode = IMM_MODE_NONE;
        known    = 1'b1;
        case (op)
            OP_W'(OP_SPECIAL): begin
                funct = funct_in;
                known = special_ok(6'(funct_in));
            end
            OP_W'(OP_SLTI):  begin funct = FUNCT_W'(FUNCT_SLT);  imm_mode = IMM_MODE_SIGN; end
            OP_W'(OP_SLTIU): begin funct = FUNCT_W'(FUNCT_SLTU); imm_mode = IMM_MODE_SIGN; end
            OP_W'(OP_ORI):   begin funct = FUNCT_W'(FUNCT_OR);   imm_mode = IMM_MODE_ZERO; end
            OP_W'(OP_LUI):   begin funct = FUNCT_W'(FUNCT_OR);   imm_mode = IMM_MODE_LUI;  end
            OP_W'(OP_JAL):   funct = FUNCT_W'(FUNCT_OR);
            OP_W'(OP_LB), OP_W'(OP_LBU), OP_W'(OP_LH), OP_W'(OP_LHU), OP_W'(OP_LW),
            OP_W'(OP_SB), OP_W'(OP_SH), OP_W'(OP_SW), OP_W'(OP_ADDI), OP_W'(OP_ADDIU): begin
                funct    = FUNCT_W'(FUNCT_ADDU);
                imm_mode = IMM_MODE_SIGN;
            end
            OP_W'(OP_PRIVILEGE), OP_W'(OP_BSPECIAL): funct = FUNCT_W'(FUNCT_ADDU);
            OP_W'(OP_ANDI):  begin funct = FUNCT_W'(FUNCT_AND);  imm_mode = IMM_MODE_ZERO; end
            OP_W'(OP_XORI):  begin funct = FUNCT_W'(FUNCT_XOR);  imm_mode = IMM_MODE_ZERO; end
            default:         known = 1'b0;
        endcase
        // empty lane slots must look like bubbles downstream
        if (!en) begin
            funct    = FUNCT_W'(FUNCT_NOP);
            imm_mode = IMM_MODE_NONE;
            known    = 1'b1;
        end
    end

`ifdef FUNCT_GEN_ILLEGAL_EN
    assign illegal = !known;
`endif

endmodule

// File: rtl/funct_gen_pipe.sv
// Multi-lane ALU FUNCT decoder with a registered 2-entry skid buffer and flush.
// FUNCT_GEN_ILLEGAL_EN adds the per-lane out_illegal output.
module funct_gen_pipe
    import funct_gen_pipe_pkg::*;
#(
    parameter int LANES   = 1,
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_lane_en,
    input  logic [LANES*OP_W-1:0]    in_op,
    input  logic [LANES*FUNCT_W-1:0] in_funct,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_lane_en,
    output logic [LANES*FUNCT_W-1:0] out_funct,
`ifdef FUNCT_GEN_ILLEGAL_EN
    output logic [LANES-1:0]         out_illegal,
`endif
    output logic [LANES*2-1:0]       out_imm_mode
);

    typedef struct packed {
        logic [LANES-1:0]              lane_en;
        logic [LANES-1:0][FUNCT_W-1:0] funct;
        logic [LANES-1:0][1:0]         imm;
`ifdef FUNCT_GEN_ILLEGAL_EN
        logic [LANES-1:0]              illegal;
`endif
    } bundle_t;

    function automatic bundle_t idle_bundle();
        bundle_t b;
        b     = '0;
        b.imm = '1;
        return b;
    endfunction

    logic [LANES-1:0][FUNCT_W-1:0] dec_funct;
    logic [LANES-1:0][1:0]         dec_imm;
`ifdef FUNCT_GEN_ILLEGAL_EN
    logic [LANES-1:0]              dec_ill;
`endif
    bundle_t dec_b, main_q, skid_q;
    state_t  state;
    logic    accept, deq;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        funct_lane_dec #(.OP_W(OP_W), .FUNCT_W(FUNCT_W)) u_dec (
            .en       (in_lane_en[i]),
            .op       (in_op[i*OP_W +: OP_W]),
            .funct_in (in_funct[i*FUNCT_W +: FUNCT_W]),
            .funct    (dec_funct[i]),
`ifdef FUNCT_GEN_ILLEGAL_EN
            .illegal  (dec_ill[i]),
`endif
            .imm_mode (dec_imm[i])
        );
    end

    always_comb begin
        dec_b         = idle_bundle();
        dec_b.lane_en = in_lane_en;
        dec_b.funct   = dec_funct;
        dec_b.imm     = dec_imm;
`ifdef FUNCT_GEN_ILLEGAL_EN
        dec_b.illegal = dec_ill;
`endif
    end

    assign accept = in_valid && in_ready;
    assign deq    = out_valid && out_ready;

    // main_q drives the outputs; skid_q only holds a bundle in FULL
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            main_q    <= idle_bundle();
            skid_q    <= idle_bundle();
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= ST_EMPTY;
            main_q    <= idle_bundle();
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: if (accept) begin
                    main_q    <= dec_b;
                    out_valid <= 1'b1;
                    state     <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (accept && !deq) begin
                        skid_q   <= dec_b;
                        in_ready <= 1'b0;
                        state    <= ST_FULL;
                    end else if (!accept && deq) begin
                        main_q    <= idle_bundle();
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end else if (accept && deq) begin
                        main_q <= dec_b;
                    end
                end
                ST_FULL: if (deq) begin
                    main_q   <= skid_q;
                    in_ready <= 1'b1;
                    state    <= ST_BUSY;
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign out_lane_en  = main_q.lane_en;
    assign out_funct    = main_q.funct;
    assign out_imm_mode = main_q.imm;
`ifdef FUNCT_GEN_ILLEGAL_EN
    assign out_illegal  = main_q.illegal;
`endif

endmodule

// File: tb/tb_funct_gen_pipe.sv
// Scoreboard bench for funct_gen_pipe with LANES=2; covers FUNCT_GEN_ILLEGAL_EN when defined.
module tb_funct_gen_pipe;

    typedef struct packed {
        logic [1:0]  en;
        logic [11:0] funct;
        logic [3:0]  imm;
        logic [1:0]  ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [1:0]  in_lane_en = '0;
    logic [11:0] in_op = '0, in_funct = '0;
    logic [1:0]  out_lane_en;
    logic [11:0] out_funct;
    logic [3:0]  out_imm_mode;
    logic [1:0]  ill_act;

    int   checks = 0, errors = 0, n_out = 0;
    bit   rand_rdy = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

`ifdef FUNCT_GEN_ILLEGAL_EN
    logic [1:0] out_illegal;
    assign ill_act = out_illegal;
`else
    assign ill_act = 2'b00;
`endif

    funct_gen_pipe #(.LANES(2), .OP_W(6), .FUNCT_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_en(in_lane_en), .in_op(in_op), .in_funct(in_funct),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_en(out_lane_en), .out_funct(out_funct),
`ifdef FUNCT_GEN_ILLEGAL_EN
        .out_illegal(out_illegal),
`endif
        .out_imm_mode(out_imm_mode)
    );

    function automatic logic [8:0] dec_lane(input logic en, input logic [5:0] op, input logic [5:0] fn);
        logic [5:0] f;
        logic [1:0] m;
        logic       il;
        f = 6'h00; m = 2'b11; il = 1'b0;
        if (en) begin
            case (op)
                6'h00: begin
                    f = fn;
                    il = !(fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                      6'h0C, 6'h0D, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19,
                                      6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                      6'h26, 6'h27, 6'h2A, 6'h2B});
                end
                6'h0A: begin f = 6'h2A; m = 2'b00; end
                6'h0B: begin f = 6'h2B; m = 2'b00; end
                6'h0D: begin f = 6'h25; m = 2'b01; end
                6'h0F: begin f = 6'h25; m = 2'b10; end
                6'h03: f = 6'h25;
                6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B, 6'h08, 6'h09:
                       begin f = 6'h21; m = 2'b00; end
                6'h10, 6'h01: f = 6'h21;
                6'h0C: begin f = 6'h24; m = 2'b01; end
                6'h0E: begin f = 6'h26; m = 2'b01; end
                default: il = 1'b1;
            endcase
        end
        return {il, m, f};
    endfunction

    function automatic exp_t model(input logic [1:0] en, input logic [11:0] op, input logic [11:0] fn);
        exp_t e;
        logic [8:0] r;
        e = '0;
        e.en = en;
        for (int i = 0; i < 2; i++) begin
            r = dec_lane(en[i], op[i*6 +: 6], fn[i*6 +: 6]);
            e.funct[i*6 +: 6] = r[5:0];
            e.imm[i*2 +: 2]   = r[7:6];
`ifdef FUNCT_GEN_ILLEGAL_EN
            e.ill[i]          = r[8];
`endif
        end
        return e;
    endfunction

    // One clock: score handshakes at the negedge, return 1 time unit after the posedge
    task automatic tick();
        exp_t act, e;
        @(negedge clk);
        act = {out_lane_en, out_funct, out_imm_mode, ill_act};
        if (rst) q.delete();
        else begin
            if (!out_valid) begin
                checks++;
                if (out_lane_en !== 2'b00) begin
                    errors++;
                    $display("FAIL idle_lane_en got %b want 00", out_lane_en);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                n_out++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got %h want no output", act);
                end else begin
                    e = q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL sb_bundle got %h want %h", act, e);
                    end
                end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(model(in_lane_en, in_op, in_funct));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] en, input logic [11:0] op, input logic [11:0] fn);
        bit acc, done;
        in_lane_en = en; in_op = op; in_funct = fn; in_valid = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            acc = in_ready;
            tick();
            done = acc;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout got in_ready=0 want accept");
        end
    endtask

    task automatic wait_drain();
        bit drained;
        out_ready = 1'b1;
        drained = 1'b0;
        for (int n = 0; n < 60 && !drained; n++) begin
            if (q.size() == 0 && !out_valid) drained = 1'b1;
            else tick();
        end
        checks++;
        if (!drained) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b1;
        tick(); tick();
        checks++;
        if ({out_valid, in_ready, out_lane_en, out_funct, out_imm_mode, ill_act} !== {1'b0, 1'b1, 2'b00, 12'h000, 4'b1111, 2'b00}) begin
            errors++;
            $display("FAIL reset got v=%b r=%b en=%b f=%h m=%b want v=0 r=1 en=00 f=000 m=1111",
                     out_valid, in_ready, out_lane_en, out_funct, out_imm_mode);
        end
        rst = 1'b0; flush = 1'b0;
        tick();
    endtask

    task automatic test_decode();
        out_ready = 1'b1;
        send(2'b11, {6'h0F, 6'h0D}, 12'h000);
        checks++;
        if ({out_valid, out_lane_en, out_funct, out_imm_mode} !== {1'b1, 2'b11, 6'h25, 6'h25, 2'b10, 2'b01}) begin
            errors++;
            $display("FAIL ori_lui got v=%b en=%b f=%h m=%b want v=1 en=11 f=965 m=1001",
                     out_valid, out_lane_en, out_funct, out_imm_mode);
        end
        wait_drain();
    endtask

    task automatic test_special();
        out_ready = 1'b1;
        send(2'b01, {6'h0D, 6'h00}, {6'h3F, 6'h2A});
        checks++;
        if ({out_lane_en, out_funct, out_imm_mode} !== {2'b01, 6'h00, 6'h2A, 2'b11, 2'b11}) begin
            errors++;
            $display("FAIL special got en=%b f=%h m=%b want en=01 f=02a m=1111",
                     out_lane_en, out_funct, out_imm_mode);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        bit acc, done;
        int base;
        base = n_out;
        out_ready = 1'b0;
        send(2'b11, {6'h0A, 6'h0E}, 12'h000);
        send(2'b11, {6'h23, 6'h0B}, 12'h000);
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            errors++;
            $display("FAIL full_ready got r=%b v=%b want r=0 v=1", in_ready, out_valid);
        end
        in_lane_en = 2'b11; in_op = {6'h0C, 6'h10}; in_funct = 12'h000; in_valid = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({in_ready, out_funct, out_imm_mode} !== {1'b0, 6'h2A, 6'h26, 2'b00, 2'b01}) begin
            errors++;
            $display("FAIL hold got r=%b f=%h m=%b want r=0 f=aa6 m=0001", in_ready, out_funct, out_imm_mode);
        end
        out_ready = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            acc = in_ready;
            tick();
            done = acc;
        end
        in_valid = 1'b0;
        wait_drain();
        checks++;
        if (n_out - base !== 3) begin
            errors++;
            $display("FAIL b2b_count got %0d want 3", n_out - base);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(2'b11, {6'h0D, 6'h0D}, 12'h000);
        send(2'b11, {6'h0E, 6'h0E}, 12'h000);
        in_lane_en = 2'b11; in_op = {6'h0C, 6'h0C}; in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready, out_lane_en} !== 4'b0100) begin
            errors++;
            $display("FAIL flush got v=%b r=%b en=%b want v=0 r=1 en=00", out_valid, in_ready, out_lane_en);
        end
        out_ready = 1'b1;
        send(2'b10, {6'h0B, 6'h00}, 12'h000);
        checks++;
        if ({out_valid, out_funct} !== {1'b1, 6'h2B, 6'h00}) begin
            errors++;
            $display("FAIL post_flush got v=%b f=%h want v=1 f=ac0", out_valid, out_funct);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(2'b11, {6'h09, 6'h08}, 12'h000);
        send(2'b11, {6'h2B, 6'h28}, 12'h000);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, in_ready, out_lane_en, out_funct, out_imm_mode, ill_act} !== {1'b0, 1'b1, 2'b00, 12'h000, 4'b1111, 2'b00}) begin
            errors++;
            $display("FAIL rst_mid got v=%b r=%b en=%b f=%h m=%b want v=0 r=1 en=00 f=000 m=1111",
                     out_valid, in_ready, out_lane_en, out_funct, out_imm_mode);
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_quiet got v=%b want 0", out_valid);
        end
    endtask

`ifdef FUNCT_GEN_ILLEGAL_EN
    task automatic test_illegal();
        out_ready = 1'b1;
        send(2'b01, {6'h00, 6'h3F}, 12'h000);
        checks++;
        if ({out_funct[5:0], out_illegal[0]} !== {6'h00, 1'b1}) begin
            errors++;
            $display("FAIL illegal_op got f=%h ill=%b want f=00 ill=1", out_funct[5:0], out_illegal[0]);
        end
        send(2'b01, {6'h00, 6'h23}, 12'h000);
        checks++;
        if ({out_funct[5:0], out_illegal[0]} !== {6'h21, 1'b0}) begin
            errors++;
            $display("FAIL legal_lw got f=%h ill=%b want f=21 ill=0", out_funct[5:0], out_illegal[0]);
        end
        wait_drain();
    endtask
`endif

    task automatic test_random();
        logic [5:0] ops [24] = '{6'h00, 6'h01, 6'h03, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                                 6'h0D, 6'h0E, 6'h0F, 6'h10, 6'h20, 6'h21, 6'h23, 6'h24,
                                 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h02, 6'h3F, 6'h11};
        logic [11:0] op;
        rand_rdy = 1'b1;
        for (int k = 0; k < 150; k++) begin
            op[5:0]  = ops[$urandom_range(0, 23)];
            op[11:6] = (k % 5 == 0) ? 6'($urandom()) : ops[$urandom_range(0, 23)];
            send(2'($urandom()), op, 12'($urandom()));
        end
        rand_rdy = 1'b0;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef FUNCT_GEN_ILLEGAL_EN
        test_illegal();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/funct_gen_pipe.md
Name: funct_gen_pipe

Overview:
Parametrised, registered successor to the ID-stage ALU-function decoder. Decodes up to LANES instructions per cycle (op, funct) into the ALU FUNCT code and an immediate-extension mode. Results pass through a 2-entry skid buffer with a valid/ready handshake, so the ID/EX boundary can stall without a combinational ready path. Flush is supported for branch/exception redirect.

Parameters:
LANES, 1, decode lanes per transfer (1..4); lane 0 is oldest
OP_W, 6, opcode width
FUNCT_W, 6, funct width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  drop all buffered entries and any input accepted this cycle
in_valid  in  1  input bundle valid
in_ready  out  1  buffer can accept; registered
in_lane_en  in  LANES  per-lane instruction present
in_op  in  LANES*OP_W  lane i at [i*OP_W +: OP_W]
in_funct  in  LANES*FUNCT_W  raw funct field per lane
out_valid  out  1  output bundle valid
out_ready  in  1  downstream accepts
out_lane_en  out  LANES  copy of in_lane_en
out_funct  out  LANES*FUNCT_W  ALU FUNCT per lane
out_imm_mode  out  LANES*2  00 sign-ext, 01 zero-ext, 10 LUI upper, 11 no immediate

Behaviour:
- Reset: out_valid=0, in_ready=1, out_lane_en=0, out_funct=0 (FUNCT_NOP), out_imm_mode=2'b11, state EMPTY. rst overrides flush and all handshakes.
- Decode per lane, op -> funct / imm_mode:
  - SPECIAL -> in_funct / 11
  - SLTI -> SLT / 00
  - SLTIU -> SLTU / 00
  - ORI -> OR / 01
  - LUI -> OR / 10
  - JAL -> OR / 11
  - LB, LBU, LH, LHU, LW, SB, SH, SW, ADDI, ADDIU -> ADDU / 00
  - PRIVILEGE, BSPECIAL -> ADDU / 11
  - ANDI -> AND / 01
  - XORI -> XOR / 01
  - any other op -> NOP / 11
- Lanes with in_lane_en[i]=0 are forced to NOP/11.
- Transfers: input occurs when in_valid && in_ready; output when out_valid && out_ready. Latency is 1 cycle from accept to out_valid when EMPTY.
- Bundle order is FIFO; bundles are never reordered or duplicated.
- State machine, on the main register plus the skid register:
  - EMPTY: accept -> BUSY.
  - BUSY: accept without output -> FULL (bundle goes to skid); output without accept -> EMPTY; both -> BUSY (main reloaded).
  - FULL: output -> BUSY (skid moves to main); in_ready=0.
- in_ready = (next state != FULL), registered.
- out_* hold stable while out_valid && !out_ready.
- flush: next state EMPTY, out_valid=0 next cycle, in_ready=1 next cycle. Any bundle presented that cycle is discarded. An output handshake in the flush cycle still counts as consumed.
- out_valid=0 implies out_lane_en=0.

Optional Feature:
Macro FUNCT_GEN_ILLEGAL_EN.
- When defined: adds port out_illegal (LANES, out), registered with the bundle. A bit is set when the lane is enabled and the op is not in the decode list above, or op=SPECIAL with a funct not in the supported SPECIAL set. Reset value 0.
- When undefined: port absent, behaviour otherwise identical.

Decomposition:
- Opcode and FUNCT constants stay in the existing shared opcode/funct include files.
- Add IMM_MODE_* constants (2-bit) to bus.v.
- One natural sub-module: funct_lane_dec, a combinational single-lane decoder instantiated LANES times with generate. The parent holds the skid buffer and FSM.

Test Plan:
- LANES=2, reset, then bundle {ORI, LUI} with out_ready=1 -> next cycle out_valid=1, out_funct={25h,25h}, imm_mode={01,10}.
- SPECIAL with funct 2Ah, lane1 disabled -> out_funct lane0=2Ah, lane1=00h, imm_mode lane1=11, out_lane_en=01.
- Hold out_ready=0 and present 3 bundles back-to-back -> two accepted, in_ready=0 after the second, the third is held. Raising out_ready drains them in order with no loss.
- flush asserted in FULL state with in_valid=1 -> next cycle out_valid=0 and in_ready=1; subsequent outputs contain none of the flushed bundles.
- rst asserted mid-FULL -> all outputs return to reset values next cycle, and the asserted flush is ignored.
- With FUNCT_GEN_ILLEGAL_EN, op=3Fh on lane0 -> out_funct=00h and out_illegal[0]=1; LW on lane0 -> ADDU (21h) and out_illegal[0]=0.
